// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    // Width of the downstream byte FIFO's data path.
    localparam int FIFO_DATA_W = 8;

    // Arbiter FSM: free round-robin scan, or holding a burst owner.
    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Round-robin picker: first set request bit at or after ptr, wrapping past N-1.
module rr_pick #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        int unsigned pos;
        logic [W-1:0] pos_w;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        pos_w = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos   = (32'(ptr) + k) % N;
            pos_w = W'(pos);
            if (!found && req[pos_w]) begin
                found = 1'b1;
                idx   = pos_w;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Shares one byte FIFO write port among NUM_REQ valid/ready producers using
// round-robin grants with an optional burst hold, a sticky handshake checker
// and a running count of accepted writes.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int MAX_BURST = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           fifo_full,
    output logic                           fifo_write_ctrl,
    output logic [DATA_W-1:0]              fifo_write_data,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic [31:0]                    total_writes,
    output logic                           protocol_error
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e                       state;
    logic [IDX_W-1:0]                 rr_ptr;
    logic [IDX_W-1:0]                 owner;
    logic [CNT_W-1:0]                 burst_cnt;
    logic [31:0]                      write_count;
    logic                             pick_found;
    logic [IDX_W-1:0]                 pick_idx;
    logic                             xfer;
    logic [IDX_W-1:0]                 widx;
    logic [NUM_REQ-1:0]               pending;
    logic [NUM_REQ-1:0][DATA_W-1:0]   snap;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == NUM_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    rr_pick #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Zero-latency grant: choose the transferring producer from state and inputs.
    always_comb begin
        req_ready = '0;
        xfer      = 1'b0;
        widx      = '0;
        if (!rst && !fifo_full) begin
            if (state == ARB_IDLE) begin
                if (pick_found) begin
                    xfer = 1'b1;
                    widx = pick_idx;
                end
            end else if (req_valid[owner]) begin
                xfer = 1'b1;
                widx = owner;
            end
            if (xfer) begin
                req_ready[widx] = 1'b1;
            end
        end
    end

    assign fifo_write_ctrl = |(req_valid & req_ready);
    assign fifo_write_data = xfer ? req_data[widx] : '0;
    assign grant_id        = widx;
    assign total_writes    = write_count;

    // Arbiter FSM: round-robin pointer, burst owner and burst length.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else if (!fifo_full) begin
            if (state == ARB_IDLE) begin
                if (pick_found) begin
                    if (MAX_BURST == 1) begin
                        rr_ptr <= next_idx(pick_idx);
                    end else begin
                        owner     <= pick_idx;
                        burst_cnt <= CNT_W'(1);
                        state     <= ARB_BURST;
                    end
                end
            end else begin
                if (req_valid[owner] && (int'(burst_cnt) + 1 != MAX_BURST)) begin
                    burst_cnt <= burst_cnt + 1'b1;
                end else begin
                    // Burst complete, or owner dropped valid (one bubble): hand on.
                    rr_ptr    <= next_idx(owner);
                    burst_cnt <= '0;
                    state     <= ARB_IDLE;
                end
            end
        end
    end

    // Count accepted writes; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_count <= '0;
        end else if (fifo_write_ctrl) begin
            write_count <= write_count + 32'd1;
        end
    end

    // Handshake checker: a stalled producer must hold valid and data next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending        <= '0;
            protocol_error <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (pending[i] && (!req_valid[i] || req_data[i] != snap[i])) begin
                    protocol_error <= 1'b1;
                end
            end
            pending <= req_valid & ~req_ready;
        end
    end

    // Data snapshot taken every cycle; only consulted when the pending bit is set.
    always_ff @(posedge clk) begin
        snap <= req_data;
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed self-checking bench for fifo_write_arbiter (pure round-robin and burst builds).
module tb_fifo_write_arbiter;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      req_valid;
    logic [3:0][7:0] req_data;
    logic            fifo_full;

    logic [3:0]  r1, r2;
    logic        w1, w2;
    logic [7:0]  d1, d2;
    logic [1:0]  g1, g2;
    logic [31:0] t1, t2;
    logic        e1, e2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(r1), .fifo_full(fifo_full), .fifo_write_ctrl(w1),
        .fifo_write_data(d1), .grant_id(g1), .total_writes(t1), .protocol_error(e1)
    );

    fifo_write_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(r2), .fifo_full(fifo_full), .fifo_write_ctrl(w2),
        .fifo_write_data(d2), .grant_id(g2), .total_writes(t2), .protocol_error(e2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; fifo_full = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    int exp3 [6] = '{0, 0, 2, 2, 0, 0};

    initial begin
        rst = 1'b1; req_valid = 4'hF; fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) req_data[i] = 8'(8'hA0 + i);

        // 1. Reset with all producers valid
        for (int c = 0; c < 2; c++) begin
            next_cyc();
            chk("rst_ready1", 32'(r1), 0);
            chk("rst_wctrl1", 32'(w1), 0);
            chk("rst_ready2", 32'(r2), 0);
            chk("rst_wctrl2", 32'(w2), 0);
            chk("rst_gid2",   32'(g2), 0);
        end
        chk("rst_total", t2, 0);
        chk("rst_perr",  32'(e2), 0);
        rst = 1'b0;
        #1;

        // 2. Pure round-robin, all valid
        for (int i = 0; i < 8; i++) begin
            chk("rr_gid",   32'(g1), 32'(i % 4));
            chk("rr_data",  32'(d1), 32'(8'hA0 + i % 4));
            chk("rr_wctrl", 32'(w1), 1);
            chk("rr_ready", 32'(r1), 32'(1 << (i % 4)));
            next_cyc();
        end
        chk("rr_total", t1, 8);
        chk("rr_perr",  32'(e1), 0);

        // 3. Burst of 2, producers 0 and 2
        reset_all();
        req_valid = 4'b0101;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("bu_gid",   32'(g2), 32'(exp3[i]));
            chk("bu_wctrl", 32'(w2), 1);
            chk("bu_data",  32'(d2), 32'(8'hA0 + exp3[i]));
            next_cyc();
        end
        // owner drops valid after one grant -> bubble, then producer 2
        reset_all();
        req_valid = 4'b0101;
        #1;
        chk("drop_gid0", 32'(g2), 0);
        next_cyc();
        req_valid = 4'b0100;
        #1;
        chk("bubble_wctrl", 32'(w2), 0);
        chk("bubble_ready", 32'(r2), 0);
        chk("bubble_data",  32'(d2), 0);
        next_cyc();
        chk("after_bubble_gid",   32'(g2), 2);
        chk("after_bubble_wctrl", 32'(w2), 1);
        chk("after_bubble_perr",  32'(e2), 0);

        // 4. FIFO full mid-burst (owner 1, burst_cnt=1)
        reset_all();
        req_valid = 4'b0110;
        #1;
        chk("full_first_gid", 32'(g2), 1);
        next_cyc();
        fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("full_wctrl", 32'(w2), 0);
            chk("full_ready", 32'(r2), 0);
            next_cyc();
        end
        fifo_full = 1'b0;
        #1;
        chk("resume_gid",   32'(g2), 1);
        chk("resume_wctrl", 32'(w2), 1);
        next_cyc();
        chk("handoff_gid",   32'(g2), 2);
        chk("handoff_wctrl", 32'(w2), 1);
        next_cyc();
        chk("full_total", t2, 3);

        // 5. Producer 3 changes data while blocked
        reset_all();
        req_data[3] = 8'h11;
        req_valid   = 4'b1001;
        #1;
        chk("viol_gid0", 32'(g2), 0);
        next_cyc();
        req_data[3] = 8'h22;
        #1;
        chk("viol_before", 32'(e2), 0);
        next_cyc();
        chk("viol_set", 32'(e2), 1);
        req_valid = '0;
        next_cyc();
        chk("viol_sticky", 32'(e2), 1);
        reset_all();
        chk("viol_cleared", 32'(e2), 0);
        req_data[3] = 8'hA3;

        // 6. total_writes wrap
        force dut.write_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.write_count;
        #1;
        chk("wrap_pre", t2, 32'hFFFF_FFFF);
        req_valid = 4'b0010;
        #1;
        chk("wrap_wctrl", 32'(w2), 1);
        next_cyc();
        chk("wrap_total", t2, 0);
        chk("wrap_perr",  32'(e2), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
